border_pad_stream: RTL and testbench
====================================

# border_pad_stream

Parametrised border-padding stage placed between the demosaic output and the windowed filter. It accepts one frame of WIDTH×HEIGHT pixels (CHANNELS × DATA_W bits each) on a valid/ready stream. It emits the same frame surrounded by PAD = (KERNEL_SIZE-1)/2 border pixels on every side. Border fill is selectable per frame: zero, constant, or horizontal edge replication. Full valid/ready backpressure lets the stage stall the upstream while it inserts border beats, so no blank-insertion timing budget is needed.

## Interface
- WIDTH, 320, active pixels per input row
- HEIGHT, 240, active rows per frame
- KERNEL_SIZE, 7, downstream kernel size; odd, ≥3
- CHANNELS, 3, colour channels per pixel
- DATA_W, 8, bits per channel
- PAD_VALUE, 0, per-channel fill used in mode 1 (DATA_W bits, replicated to all channels)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- newFrame  in  1  start-of-frame pulse; honoured only in IDLE
- iMode  in  2  fill mode, sampled when newFrame is accepted: 0 zero, 1 PAD_VALUE, 2 edge replicate, 3 treated as 0
- iValid  in  1  input pixel valid
- iReady  out  1  input pixel accepted when iValid & iReady
- iData  in  CHANNELS*DATA_W  input pixel, channel 0 in MSBs
- oValid  out  1  output beat valid
- oReady  in  1  downstream accepts beat when oValid & oReady
- oData  out  CHANNELS*DATA_W  output beat
- oLast  out  1  high with the last beat of each padded row
- oDone  out  1  one-cycle pulse after final beat of frame transfers

## Operation
- PAD = (KERNEL_SIZE-1)/2; padded row PW = WIDTH+2·PAD beats; padded frame = (HEIGHT+2·PAD)·PW beats.
- States: IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM, DONE.
- IDLE: iReady=0. newFrame → latch mode, x=y=0, go TOP.
- TOP: emit PAD rows of fill; then LEFT.
- LEFT: emit PAD fill beats, then BODY.
- BODY: pass WIDTH input pixels; then RIGHT.
- RIGHT: emit PAD fill beats; then LEFT if rows remain, else BOTTOM.
- BOTTOM: emit PAD rows of fill; then DONE.
- DONE: pulse oDone for one cycle; then IDLE.
- Fill in TOP/BOTTOM: zero in modes 0/2/3; PAD_VALUE per channel in mode 1.
- Fill in LEFT/RIGHT: modes 0/1 as for TOP/BOTTOM.
- Mode 2, LEFT: replicate the row's first pixel by peeking iData. Each left-border beat waits for iValid and does not consume the pixel.
- Mode 2, RIGHT: replicate the last accepted BODY pixel, held in a register.
- Upstream must hold iData stable while iValid=1 and the pixel has not been accepted.
- Output register advance condition: !oValid | oReady.
- iReady = (state==BODY) & advance, combinational from oReady.
- In modes 0/1, fill beats never depend on iValid.
- oLast is set when loading the last beat of any padded row, including TOP and BOTTOM rows.
- newFrame outside IDLE is ignored. iMode changes mid-frame are ignored.
- Column counter range is 0..PW-1. Row counter range is 0..HEIGHT+2·PAD-1. Both are 16 bits.

## Timing
- Reset values: oValid=0, oData=0, oLast=0, oDone=0, iReady=0, state=IDLE.
- Reset mid-frame: all of the above on the next cycle; partial frame abandoned.
- newFrame accepted in cycle t → first TOP beat valid at t+1.
- Input pixel accepted in cycle t → same pixel on oData at t+1.
- With oReady held high, throughput is 1 beat/cycle. Modes 0/1 then need exactly (HEIGHT+2·PAD)·PW cycles from first to last beat.
- oValid/oData/oLast hold while oValid & !oReady.
- oDone is high on the cycle after the final beat handshake; the block is in IDLE the following cycle.
- newFrame arriving in the same cycle as oDone is ignored; it is accepted from the next cycle onward.

## Test plan
- Zero fill: WIDTH=4, HEIGHT=3, KERNEL_SIZE=3, mode 0, pixels 1..12, oReady=1 → 30 beats. Beats 0–5 and 6 are 0; beats 7–10 are 1,2,3,4; beat 11 is 0. oLast at beats 5,11,…,29. oDone one cycle after beat 29.
- Replicate: same geometry, mode 2 → padded row 2 is 1,1,2,3,4,4. Top and bottom rows are all 0. Row 4 is 9,9,10,11,12,12.
- Constant + backpressure: mode 1, PAD_VALUE=8'h80, oReady toggling 1/0 each cycle → border beats 0x808080. No beat lost or duplicated; oData stable while stalled; 30 beats total.
- Upstream gaps: iValid low 3 cycles before every 2nd pixel, mode 2 → left border waits for iValid. Output content identical to the replicate case; iReady only in BODY.
- Reset mid-frame after beat 15, then newFrame → outputs 0 the cycle after reset. The new frame starts with a clean TOP row of 6 zero beats.
- newFrame pulsed mid-frame and in the oDone cycle → ignored. Exactly one 30-beat frame is produced.

Source files
------------

// File: rtl/border_pad_stream_if.sv
// ----------------------------------------------------------------------------
// border_pad_stream_if
//
// Purpose: groups the frame-control, input-stream and output-stream signals of
// the border padding stage so they travel as one bundle.
//
// Signals:
//   newFrame  start-of-frame request, honoured only while the stage is idle
//   iMode     fill mode for the frame being started
//   iValid    input pixel valid
//   iReady    input pixel accepted when iValid & iReady
//   iData     input pixel, channel 0 in the MSBs
//   oValid    output beat valid
//   oReady    downstream accepts the beat when oValid & oReady
//   oData     output beat
//   oLast     marks the last beat of each padded row
//   oDone     one-cycle pulse after the final beat of a frame has transferred
//
// Modports:
//   master  the side that feeds pixels in and drains beats out
//   slave   the padding stage itself
// ----------------------------------------------------------------------------
interface border_pad_stream_if #(
    parameter int CHANNELS = 3,
    parameter int DATA_W   = 8
);
    logic                         newFrame;
    logic [1:0]                   iMode;
    logic                         iValid;
    logic                         iReady;
    logic [CHANNELS*DATA_W-1:0]   iData;
    logic                         oValid;
    logic                         oReady;
    logic [CHANNELS*DATA_W-1:0]   oData;
    logic                         oLast;
    logic                         oDone;

    modport master (
        output newFrame, iMode, iValid, iData, oReady,
        input  iReady, oValid, oData, oLast, oDone
    );

    modport slave (
        input  newFrame, iMode, iValid, iData, oReady,
        output iReady, oValid, oData, oLast, oDone
    );
endinterface

// File: rtl/border_pad_stream.sv
// ----------------------------------------------------------------------------
// border_pad_stream
//
// Purpose: takes one WIDTH x HEIGHT frame on a valid/ready stream and emits it
// surrounded by PAD = (KERNEL_SIZE-1)/2 border pixels on every side, so the
// following windowed filter sees a full kernel at the image edges. The border
// is zero, a constant (PAD_VALUE per channel) or a horizontal replica of the
// row's edge pixels, chosen per frame. Backpressure on both sides lets the
// stage stall the upstream while it inserts border beats.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; abandons any partial frame
//   bus    border_pad_stream_if.slave bundle (frame control, input stream,
//          output stream, done pulse)
// ----------------------------------------------------------------------------
module border_pad_stream #(
    parameter int                WIDTH       = 320,
    parameter int                HEIGHT      = 240,
    parameter int                KERNEL_SIZE = 7,
    parameter int                CHANNELS    = 3,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] PAD_VALUE   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    border_pad_stream_if.slave     bus
);

    localparam int PAD   = (KERNEL_SIZE - 1) / 2;
    localparam int PW    = WIDTH + 2 * PAD;
    localparam int PH    = HEIGHT + 2 * PAD;
    localparam int PIX_W = CHANNELS * DATA_W;

    localparam logic [15:0] COL_LAST     = 16'(PW - 1);
    localparam logic [15:0] COL_LEFT_END = 16'(PAD - 1);
    localparam logic [15:0] COL_BODY_END = 16'(PAD + WIDTH - 1);
    localparam logic [15:0] ROW_TOP_END  = 16'(PAD - 1);
    localparam logic [15:0] ROW_BODY_END = 16'(PAD + HEIGHT - 1);
    localparam logic [15:0] ROW_LAST     = 16'(PH - 1);

    typedef enum logic [2:0] {
        IDLE,
        TOP,
        LEFT,
        BODY,
        RIGHT,
        BOTTOM,
        DONE
    } state_t;

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [15:0]        col_q;
    logic [15:0]        row_q;
    logic [PIX_W-1:0]   edge_q;
    logic [PIX_W-1:0]   oData_q;
    logic               oValid_q;
    logic               oLast_q;
    logic               oDone_q;

    logic [15:0]        col_d;
    logic [15:0]        row_d;
    logic               advance;
    logic               replicate;
    logic               colAtLast;
    logic [PIX_W-1:0]   fill;

    // Constant fill for a given mode: only mode 1 uses PAD_VALUE, every other
    // mode (including the reserved value 3) borders with zero.
    function automatic logic [PIX_W-1:0] fillFor(input logic [1:0] mode);
        fillFor = (mode == 2'd1) ? {CHANNELS{PAD_VALUE}} : '0;
    endfunction

    // The output register may take a new beat when it is empty or its current
    // beat is being accepted this cycle.
    assign advance   = !oValid_q || bus.oReady;
    assign replicate = (mode_q == 2'd2);
    assign fill      = fillFor(mode_q);
    assign colAtLast = (col_q == COL_LAST);
    assign col_d     = colAtLast ? 16'd0 : col_q + 16'd1;
    assign row_d     = row_q + 16'd1;

    // Pixels are only taken while passing the active part of a row, and only
    // when the output register can accept them in the same cycle.
    assign bus.iReady = (state_q == BODY) && advance;

    assign bus.oValid = oValid_q;
    assign bus.oData  = oData_q;
    assign bus.oLast  = oLast_q;
    assign bus.oDone  = oDone_q;

    // Frame sequencer and output register. Each state loads at most one beat
    // per cycle when the output register can advance; the column counter runs
    // across the whole padded row and the row counter across the padded frame.
    // Leaving IDLE already loads the first top-border beat so the frame starts
    // on the cycle right after newFrame is taken. In replicate mode the left
    // border peeks at the waiting first pixel of the row without consuming it,
    // and the right border reuses the last body pixel held in edge_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= 2'd0;
            col_q    <= 16'd0;
            row_q    <= 16'd0;
            edge_q   <= '0;
            oData_q  <= '0;
            oValid_q <= 1'b0;
            oLast_q  <= 1'b0;
            oDone_q  <= 1'b0;
        end else begin
            oDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.newFrame) begin
                        mode_q   <= (bus.iMode == 2'd3) ? 2'd0 : bus.iMode;
                        oValid_q <= 1'b1;
                        oData_q  <= fillFor(bus.iMode);
                        oLast_q  <= (COL_LAST == 16'd0);
                        col_q    <= 16'd1;
                        row_q    <= 16'd0;
                        state_q  <= TOP;
                    end
                end

                TOP, BOTTOM: begin
                    if (advance) begin
                        oValid_q <= 1'b1;
                        oData_q  <= fill;
                        oLast_q  <= colAtLast;
                        col_q    <= col_d;
                        if (colAtLast) begin
                            row_q <= row_d;
                            if (state_q == TOP && row_q == ROW_TOP_END) begin
                                state_q <= LEFT;
                            end else if (state_q == BOTTOM && row_q == ROW_LAST) begin
                                state_q <= DONE;
                            end
                        end
                    end
                end

                LEFT: begin
                    if (advance) begin
                        if (replicate && !bus.iValid) begin
                            oValid_q <= 1'b0;
                            oLast_q  <= 1'b0;
                        end else begin
                            oValid_q <= 1'b1;
                            oData_q  <= replicate ? bus.iData : fill;
                            oLast_q  <= 1'b0;
                            col_q    <= col_d;
                            if (col_q == COL_LEFT_END) begin
                                state_q <= BODY;
                            end
                        end
                    end
                end

                BODY: begin
                    if (advance) begin
                        if (bus.iValid) begin
                            oValid_q <= 1'b1;
                            oData_q  <= bus.iData;
                            edge_q   <= bus.iData;
                            oLast_q  <= 1'b0;
                            col_q    <= col_d;
                            if (col_q == COL_BODY_END) begin
                                state_q <= RIGHT;
                            end
                        end else begin
                            oValid_q <= 1'b0;
                            oLast_q  <= 1'b0;
                        end
                    end
                end

                RIGHT: begin
                    if (advance) begin
                        oValid_q <= 1'b1;
                        oData_q  <= replicate ? edge_q : fill;
                        oLast_q  <= colAtLast;
                        col_q    <= col_d;
                        if (colAtLast) begin
                            row_q   <= row_d;
                            state_q <= (row_q == ROW_BODY_END) ? BOTTOM : LEFT;
                        end
                    end
                end

                DONE: begin
                    // The final beat is already in the output register; once it
                    // drains, pulse oDone for a cycle while still refusing
                    // newFrame, then return to IDLE.
                    if (oDone_q) begin
                        state_q <= IDLE;
                    end else if (advance) begin
                        oValid_q <= 1'b0;
                        oLast_q  <= 1'b0;
                        oDone_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_border_pad_stream.sv
// ----------------------------------------------------------------------------
// tb_border_pad_stream
//
// Purpose: directed bench for border_pad_stream on a 4x3 frame with a 3x3
// kernel (one-pixel border, 6x5 padded frame, 30 beats).
//
// Ports: none (top-level bench). Drives the interface as master, owns the
// clock and reset.
// ----------------------------------------------------------------------------
module tb_border_pad_stream;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int K   = 3;
    localparam int CH  = 3;
    localparam int DW  = 8;
    localparam int NB  = 30;
    localparam int NPX = W * H;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    border_pad_stream_if #(.CHANNELS(CH), .DATA_W(DW)) bus ();

    border_pad_stream #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .KERNEL_SIZE(K),
        .CHANNELS   (CH),
        .DATA_W     (DW),
        .PAD_VALUE  (8'h80)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] gotData [0:63];
    logic        gotLast [0:63];
    int beatCount;
    int firstValidCyc;
    int firstHsCyc;
    int finalHsCyc;
    int doneCyc;
    int doneCount;
    int stallViol;
    int acceptCount;
    int timedOut;
    logic        snapValid;
    logic [23:0] snapData;
    logic        snapLast;
    logic        snapDone;
    logic        snapReady;

    // Input pixel k (0-based) carries value k+1 on channel 0, with offsets on
    // the other channels so channel swaps are visible.
    function automatic logic [23:0] pixVal(input int k);
        logic [7:0] v;
        v = 8'(k + 1);
        return {v, v + 8'h10, v + 8'h20};
    endfunction

    // Expected padded beat idx for the 6x5 padded frame.
    function automatic logic [23:0] expBeat(input int mode, input int idx);
        int r;
        int c;
        logic [23:0] fillV;
        r = idx / 6;
        c = idx % 6;
        fillV = (mode == 1) ? 24'h808080 : 24'h000000;
        if (r == 0 || r == 4) return fillV;
        if (c == 0) return (mode == 2) ? pixVal((r - 1) * 4) : fillV;
        if (c == 5) return (mode == 2) ? pixVal((r - 1) * 4 + 3) : fillV;
        return pixVal((r - 1) * 4 + c - 1);
    endfunction

    // Starts one frame and drives/observes it cycle by cycle. Inputs are set
    // on the falling edge, handshakes are judged 1 time unit later, ahead of
    // the rising edge that will act on them.
    task automatic applyStimulus(input int mode, input bit toggleReady, input bit gaps,
                                 input int resetAfterBeat, input bit injectNewFrame,
                                 input int tail, input int budget);
        int  pix;
        int  gapCnt;
        int  cyc;
        int  resetPhase;
        bit  prevStall;
        bit  finished;
        logic [23:0] prevData;
        logic        prevLast;
        beatCount = 0; firstValidCyc = -1; firstHsCyc = -1; finalHsCyc = -1;
        doneCyc = -1; doneCount = 0; stallViol = 0; acceptCount = 0; timedOut = 0;
        for (int i = 0; i < 64; i++) begin
            gotData[i] = 'x;
            gotLast[i] = 1'bx;
        end
        pix = 0; gapCnt = 0; cyc = 0; resetPhase = 0;
        prevStall = 0; finished = 0; prevData = '0; prevLast = 0;

        @(negedge clk);
        bus.newFrame = 1'b1;
        bus.iMode    = 2'(mode);
        bus.iValid   = 1'b0;
        bus.oReady   = 1'b1;
        @(negedge clk);
        bus.newFrame = 1'b0;

        while (!finished) begin
            if (cyc >= budget) begin
                timedOut = 1;
                break;
            end
            if (resetPhase == 1) begin
                reset = 1'b1;
                bus.iValid = 1'b0;
                resetPhase = 2;
                cyc++;
                @(negedge clk);
                continue;
            end
            if (resetPhase == 2) begin
                reset = 1'b0;
                #1;
                snapValid = bus.oValid;
                snapData  = bus.oData;
                snapLast  = bus.oLast;
                snapDone  = bus.oDone;
                snapReady = bus.iReady;
                break;
            end

            bus.newFrame = 1'b0;
            if (injectNewFrame && (cyc == 10 || (finalHsCyc >= 0 && cyc == finalHsCyc + 1)))
                bus.newFrame = 1'b1;
            bus.oReady = toggleReady ? (cyc % 2 == 0) : 1'b1;
            if (pix < NPX) begin
                if (gaps && (pix % 2 == 0) && gapCnt < 3) begin
                    bus.iValid = 1'b0;
                    gapCnt++;
                end else begin
                    bus.iValid = 1'b1;
                    bus.iData  = pixVal(pix);
                end
            end else begin
                bus.iValid = 1'b0;
            end

            #1;
            if (bus.oValid === 1'b1 && firstValidCyc < 0) firstValidCyc = cyc;
            if (prevStall && (bus.oValid !== 1'b1 || bus.oData !== prevData || bus.oLast !== prevLast))
                stallViol++;
            prevStall = (bus.oValid === 1'b1) && !bus.oReady;
            prevData  = bus.oData;
            prevLast  = bus.oLast;
            if (bus.oDone === 1'b1) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (bus.iValid && bus.iReady === 1'b1) begin
                acceptCount++;
                pix++;
                gapCnt = 0;
            end
            if (bus.oValid === 1'b1 && bus.oReady) begin
                if (beatCount < 64) begin
                    gotData[beatCount] = bus.oData;
                    gotLast[beatCount] = bus.oLast;
                end
                if (firstHsCyc < 0) firstHsCyc = cyc;
                beatCount++;
                if (beatCount == NB) finalHsCyc = cyc;
            end
            if (resetAfterBeat >= 0 && resetPhase == 0 && beatCount == resetAfterBeat + 1)
                resetPhase = 1;
            if (doneCyc >= 0 && cyc >= doneCyc + tail) finished = 1;
            cyc++;
            @(negedge clk);
        end
        bus.iValid   = 1'b0;
        bus.newFrame = 1'b0;
        bus.oReady   = 1'b1;
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.newFrame = 1'b0; bus.iMode = 2'd0; bus.iValid = 1'b0;
        bus.iData = '0; bus.oReady = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_oValid got %b expected 0", bus.oValid); end
        checks++; if (bus.oData !== 24'h0) begin errors++; $display("[TB] FAIL reset_oData got %h expected 000000", bus.oData); end
        checks++; if (bus.oLast !== 1'b0) begin errors++; $display("[TB] FAIL reset_oLast got %b expected 0", bus.oLast); end
        checks++; if (bus.oDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_oDone got %b expected 0", bus.oDone); end
        checks++; if (bus.iReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_iReady got %b expected 0", bus.iReady); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_fill();
        applyStimulus(0, 0, 0, -1, 0, 2, 300);
        checks++; if (timedOut !== 0) begin errors++; $display("[TB] FAIL zero_timeout got %0d expected 0", timedOut); end
        checks++; if (beatCount !== NB) begin errors++; $display("[TB] FAIL zero_beats got %0d expected %0d", beatCount, NB); end
        checks++; if (firstValidCyc !== 0) begin errors++; $display("[TB] FAIL zero_latency got %0d expected 0", firstValidCyc); end
        checks++; if (finalHsCyc - firstHsCyc !== NB - 1) begin errors++; $display("[TB] FAIL zero_span got %0d expected %0d", finalHsCyc - firstHsCyc, NB - 1); end
        checks++; if (gotData[7] !== 24'h011121) begin errors++; $display("[TB] FAIL zero_beat7 got %h expected 011121", gotData[7]); end
        checks++; if (gotData[11] !== 24'h000000) begin errors++; $display("[TB] FAIL zero_beat11 got %h expected 000000", gotData[11]); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (gotData[i] !== expBeat(0, i) || gotLast[i] !== (i % 6 == 5)) begin
                errors++;
                $display("[TB] FAIL zero_beat%0d got %h/%b expected %h/%b", i, gotData[i], gotLast[i], expBeat(0, i), (i % 6 == 5));
            end
        end
        checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL zero_doneCount got %0d expected 1", doneCount); end
        checks++; if (doneCyc !== finalHsCyc + 1) begin errors++; $display("[TB] FAIL zero_doneCycle got %0d expected %0d", doneCyc, finalHsCyc + 1); end
        checks++; if (acceptCount !== NPX) begin errors++; $display("[TB] FAIL zero_accepts got %0d expected %0d", acceptCount, NPX); end
    endtask

    task automatic test_replicate();
        applyStimulus(2, 0, 0, -1, 0, 2, 300);
        checks++; if (beatCount !== NB) begin errors++; $display("[TB] FAIL repl_beats got %0d expected %0d", beatCount, NB); end
        checks++; if (gotData[6] !== 24'h011121) begin errors++; $display("[TB] FAIL repl_leftEdge got %h expected 011121", gotData[6]); end
        checks++; if (gotData[11] !== 24'h041424) begin errors++; $display("[TB] FAIL repl_rightEdge got %h expected 041424", gotData[11]); end
        checks++; if (gotData[29] !== 24'h000000) begin errors++; $display("[TB] FAIL repl_bottom got %h expected 000000", gotData[29]); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (gotData[i] !== expBeat(2, i) || gotLast[i] !== (i % 6 == 5)) begin
                errors++;
                $display("[TB] FAIL repl_beat%0d got %h/%b expected %h/%b", i, gotData[i], gotLast[i], expBeat(2, i), (i % 6 == 5));
            end
        end
        checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL repl_doneCount got %0d expected 1", doneCount); end
    endtask

    task automatic test_constant_backpressure();
        applyStimulus(1, 1, 0, -1, 0, 2, 400);
        checks++; if (beatCount !== NB) begin errors++; $display("[TB] FAIL const_beats got %0d expected %0d", beatCount, NB); end
        checks++; if (stallViol !== 0) begin errors++; $display("[TB] FAIL const_stall got %0d expected 0", stallViol); end
        checks++; if (gotData[0] !== 24'h808080) begin errors++; $display("[TB] FAIL const_beat0 got %h expected 808080", gotData[0]); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (gotData[i] !== expBeat(1, i) || gotLast[i] !== (i % 6 == 5)) begin
                errors++;
                $display("[TB] FAIL const_beat%0d got %h/%b expected %h/%b", i, gotData[i], gotLast[i], expBeat(1, i), (i % 6 == 5));
            end
        end
        checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL const_doneCount got %0d expected 1", doneCount); end
        checks++; if (doneCyc !== finalHsCyc + 1) begin errors++; $display("[TB] FAIL const_doneCycle got %0d expected %0d", doneCyc, finalHsCyc + 1); end
    endtask

    task automatic test_upstream_gaps();
        applyStimulus(2, 0, 1, -1, 0, 2, 400);
        checks++; if (timedOut !== 0) begin errors++; $display("[TB] FAIL gaps_timeout got %0d expected 0", timedOut); end
        checks++; if (beatCount !== NB) begin errors++; $display("[TB] FAIL gaps_beats got %0d expected %0d", beatCount, NB); end
        checks++; if (acceptCount !== NPX) begin errors++; $display("[TB] FAIL gaps_accepts got %0d expected %0d", acceptCount, NPX); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (gotData[i] !== expBeat(2, i) || gotLast[i] !== (i % 6 == 5)) begin
                errors++;
                $display("[TB] FAIL gaps_beat%0d got %h/%b expected %h/%b", i, gotData[i], gotLast[i], expBeat(2, i), (i % 6 == 5));
            end
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(0, 0, 0, 15, 0, 2, 300);
        checks++; if (beatCount !== 16) begin errors++; $display("[TB] FAIL rstmid_beats got %0d expected 16", beatCount); end
        checks++; if (snapValid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_oValid got %b expected 0", snapValid); end
        checks++; if (snapData !== 24'h0) begin errors++; $display("[TB] FAIL rstmid_oData got %h expected 000000", snapData); end
        checks++; if (snapLast !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_oLast got %b expected 0", snapLast); end
        checks++; if (snapDone !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_oDone got %b expected 0", snapDone); end
        checks++; if (snapReady !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_iReady got %b expected 0", snapReady); end
        applyStimulus(0, 0, 0, -1, 0, 2, 300);
        checks++; if (beatCount !== NB) begin errors++; $display("[TB] FAIL rstmid_newBeats got %0d expected %0d", beatCount, NB); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (gotData[i] !== expBeat(0, i) || gotLast[i] !== (i % 6 == 5)) begin
                errors++;
                $display("[TB] FAIL rstmid_beat%0d got %h/%b expected %h/%b", i, gotData[i], gotLast[i], expBeat(0, i), (i % 6 == 5));
            end
        end
        checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL rstmid_doneCount got %0d expected 1", doneCount); end
    endtask

    task automatic test_ignored_newframe();
        applyStimulus(0, 0, 0, -1, 1, 40, 400);
        checks++; if (beatCount !== NB) begin errors++; $display("[TB] FAIL ignore_beats got %0d expected %0d", beatCount, NB); end
        checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL ignore_doneCount got %0d expected 1", doneCount); end
        checks++; if (gotData[8] !== 24'h021222) begin errors++; $display("[TB] FAIL ignore_beat8 got %h expected 021222", gotData[8]); end
    endtask

    initial begin
        reset = 1'b1;
        bus.newFrame = 1'b0; bus.iMode = 2'd0; bus.iValid = 1'b0;
        bus.iData = '0; bus.oReady = 1'b1;
        test_reset();
        test_zero_fill();
        test_replicate();
        test_constant_backpressure();
        test_upstream_gaps();
        test_reset_mid();
        test_ignored_newframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
